// File: rtl/lvds_sd_frontend.sv
// LVDS sigma-delta front end. Each channel provides integrator feedback and a synchronised
// bit stream, decoded to raw +/-1 or boxcar-decimated samples, with stuck-input detection.
module lvds_sd_frontend #(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DECIM       = 16,
  parameter int STUCK_LIMIT = 1024
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         en,
  input  logic                         mode,
  input  logic [NUM_CH-1:0]            invert,
  input  logic [NUM_CH-1:0]            lvds_in,
  output logic [NUM_CH-1:0]            integrator_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic [NUM_CH-1:0]            stuck
);
  localparam int AW = $clog2(DECIM) + 2;
  localparam int CW = $clog2(DECIM);
  localparam int RW = $clog2(STUCK_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(STUCK_LIMIT);
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (DATA_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (DATA_WIDTH - 1));

  logic          mode_q;
  logic [CW-1:0] cnt_q;
  logic          mode_chg;
  logic          box_step;
  logic          dump;

  // A mode change costs one clock: everything restarts and the new mode runs next clock.
  assign mode_chg = (mode != mode_q);
  assign box_step = en && mode_q && !mode_chg;
  assign dump     = box_step && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      integrator_out <= '0;
    end else begin
      integrator_out <= lvds_in;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      data_valid <= 1'b0;
    end else if (mode_chg) begin
      mode_q     <= mode;
      cnt_q      <= '0;
      data_valid <= 1'b0;
    end else if (en) begin
      if (mode_q) begin
        data_valid <= dump;
        cnt_q      <= dump ? '0 : cnt_q + CW'(1);
      end else begin
        data_valid <= 1'b1;
      end
    end else begin
      data_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bit_s;
    logic                   bit_q;
    logic [RW-1:0]          run_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   sample;
    logic signed [AW-1:0]   sum;
    logic signed [31:0]     sum_ext;
    logic [DATA_WIDTH-1:0]  sat_val;
    logic [DATA_WIDTH-1:0]  raw_val;
    logic [DATA_WIDTH-1:0]  dout_q;

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], integrator_out[c]};
      end
    end

    // Comparator high means the integrator is above threshold, i.e. a -1 sample.
    assign bit_s   = sync_q[SYNC_STAGES-1] ^ invert[c];
    assign sample  = bit_s ? {AW{1'b1}} : AW'(1);
    assign raw_val = bit_s ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(1);
    assign sum     = acc_q + sample;
    assign sum_ext = {{(32-AW){sum[AW-1]}}, sum};

    always_comb begin
      sat_val = sum_ext[DATA_WIDTH-1:0];
      if (sum_ext > SAT_MAX) begin
        sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (sum_ext < SAT_MIN) begin
        sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        acc_q  <= '0;
        dout_q <= '0;
      end else if (mode_chg) begin
        acc_q <= '0;
      end else if (en) begin
        if (!mode_q) begin
          dout_q <= raw_val;
        end else if (dump) begin
          dout_q <= sat_val;
          acc_q  <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        bit_q <= 1'b0;
        run_q <= '0;
      end else begin
        bit_q <= bit_s;
        if (bit_s != bit_q) begin
          run_q <= RW'(1);
        end else if (run_q != RUN_MAX) begin
          run_q <= run_q + RW'(1);
        end
      end
    end

    assign stuck[c] = (run_q == RUN_MAX);
    assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = dout_q;
  end

endmodule

// File: tb/tb_lvds_sd_frontend.sv
// Randomised bench for lvds_sd_frontend: 12-bit and 4-bit instances share stimulus and are
// compared every clock against an integer-arithmetic model of the sample stream.
module tb_lvds_sd_frontend;
  localparam int DECIM = 16;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic        mode;
  logic [1:0]  inv;
  logic [1:0]  lvds;
  logic [1:0]  integ, integ4;
  logic [23:0] dout12;
  logic [7:0]  dout4;
  logic        valid, valid4;
  logic [1:0]  stuck, stuck4;

  int total = 0;
  int bad   = 0;

  logic [1:0] hist [$];
  logic [1:0] m_integ;
  int         m_cnt;
  int         m_sum  [2];
  int         m_d12  [2];
  int         m_d4   [2];
  int         m_run  [2];
  logic       m_prev [2];
  logic       m_valid;
  logic       m_mode;

  lvds_sd_frontend #(.DATA_WIDTH(12), .NUM_CH(2), .SYNC_STAGES(2), .DECIM(DECIM),
                     .STUCK_LIMIT(LIMIT)) u_dut (
    .clk(clk), .arst_n(arst_n), .en(en), .mode(mode), .invert(inv), .lvds_in(lvds),
    .integrator_out(integ), .data_out(dout12), .data_valid(valid), .stuck(stuck));

  lvds_sd_frontend #(.DATA_WIDTH(4), .NUM_CH(2), .SYNC_STAGES(2), .DECIM(DECIM),
                     .STUCK_LIMIT(LIMIT)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .en(en), .mode(mode), .invert(inv), .lvds_in(lvds),
    .integrator_out(integ4), .data_out(dout4), .data_valid(valid4), .stuck(stuck4));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic model_reset();
    hist = '{2'b00, 2'b00, 2'b00};
    m_integ = 2'b00;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_mode  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_sum[c] = 0; m_d12[c] = 0; m_d4[c] = 0; m_run[c] = 0; m_prev[c] = 1'b0;
    end
  endtask

  // Bits reach the decoder three clocks after lvds_in is sampled (input register + two syncs).
  task automatic model_edge();
    logic [1:0] old;
    logic       s;
    int         v [2];
    old = hist.pop_front();
    hist.push_back(lvds);
    m_integ = lvds;
    for (int c = 0; c < 2; c++) begin
      s = old[c] ^ inv[c];
      v[c] = s ? -1 : 1;
      if (s != m_prev[c]) m_run[c] = 1;
      else if (m_run[c] < LIMIT) m_run[c]++;
      m_prev[c] = s;
    end
    if (mode != m_mode) begin
      m_mode = mode; m_cnt = 0; m_valid = 1'b0;
      m_sum[0] = 0; m_sum[1] = 0;
    end else if (en) begin
      if (!m_mode) begin
        for (int c = 0; c < 2; c++) begin m_d12[c] = v[c]; m_d4[c] = v[c]; end
        m_valid = 1'b1;
      end else begin
        for (int c = 0; c < 2; c++) m_sum[c] += v[c];
        if (m_cnt == DECIM - 1) begin
          for (int c = 0; c < 2; c++) begin
            m_d12[c] = sat(m_sum[c], 12); m_d4[c] = sat(m_sum[c], 4); m_sum[c] = 0;
          end
          m_cnt = 0; m_valid = 1'b1;
        end else begin
          m_cnt++; m_valid = 1'b0;
        end
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] e12;
    logic [7:0]  e4;
    logic [1:0]  es;
    for (int c = 0; c < 2; c++) begin
      e12[c*12 +: 12] = 12'(m_d12[c]);
      e4[c*4 +: 4]    = 4'(m_d4[c]);
      es[c]           = (m_run[c] == LIMIT);
    end
    chk({tag, ".integ"},  64'(integ),  64'(m_integ));
    chk({tag, ".integ4"}, 64'(integ4), 64'(m_integ));
    chk({tag, ".dout"},   64'(dout12), 64'(e12));
    chk({tag, ".dout4"},  64'(dout4),  64'(e4));
    chk({tag, ".valid"},  64'(valid),  64'(m_valid));
    chk({tag, ".valid4"}, 64'(valid4), 64'(m_valid));
    chk({tag, ".stuck"},  64'(stuck),  64'(es));
    chk({tag, ".stuck4"}, 64'(stuck4), 64'(es));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic ticks_to_valid(input string tag, output int n);
    n = 0;
    do begin
      tick(tag);
      n++;
    end while (!valid && n < 40);
  endtask

  initial begin
    int n;
    arst_n = 1'b0; en = 1'b0; mode = 1'b0; inv = 2'b00; lvds = 2'b00;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    arst_n = 1'b1;

    // raw mode: ch0 comparator high -> -1, ch1 low -> +1
    en = 1'b1; lvds = 2'b01;
    repeat (6) tick("raw");
    chk("raw_ch0", 64'(dout12[11:0]), 64'h0FFF);
    chk("raw_ch1", 64'(dout12[23:12]), 64'h0001);
    inv = 2'b01;
    repeat (4) tick("raw_inv");
    chk("raw_inv_ch0", 64'(dout12[11:0]), 64'h0001);
    inv = 2'b00;

    // boxcar: ch0 alternating, ch1 constant 0
    mode = 1'b1;
    for (int i = 0; i < 50; i++) begin
      lvds = {1'b0, lvds[0] ^ 1'b1};
      tick("box_alt");
    end
    chk("box_alt_ch1", 64'(dout12[23:12]), 64'h0010);

    // saturation on the 4-bit instance
    lvds = 2'b00;
    repeat (40) tick("sat_pos");
    chk("sat_pos4", 64'(dout4), 64'h77);
    lvds = 2'b11;
    repeat (40) tick("sat_neg");
    chk("sat_neg4", 64'(dout4), 64'h88);

    // en low for 5 clocks at counter 9
    n = 0;
    while (m_cnt != 9 && n < 40) begin
      lvds = 2'($urandom_range(0, 3));
      tick("seek9");
      n++;
    end
    chk("seek9_reached", 64'(m_cnt), 64'd9);
    en = 1'b0;
    repeat (5) tick("en_low");
    en = 1'b1;
    ticks_to_valid("en_resume", n);
    chk("en_hold_delay", 64'(n), 64'd7);

    // mode toggle mid-window restarts a full window
    repeat (5) tick("pre_toggle");
    mode = 1'b0;
    tick("mode_chg");
    chk("mode_chg_valid", 64'(valid), 64'd0);
    mode = 1'b1;
    ticks_to_valid("mode_back", n);
    chk("mode_window", 64'(n), 64'd17);

    // stuck detection on ch0 while ch1 keeps toggling
    lvds = 2'b00;
    for (int i = 0; i < 14; i++) begin
      lvds[1] = ~lvds[1];
      tick("stuck_hold");
    end
    chk("stuck0_set", 64'(stuck[0]), 64'd1);
    lvds[0] = 1'b1;
    repeat (4) tick("stuck_toggle");
    chk("stuck0_clr", 64'(stuck[0]), 64'd0);

    // randomised run
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 9) < 3) lvds[c] = ~lvds[c];
      if ($urandom_range(0, 199) == 0) inv = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      tick("rand");
    end

    // async reset mid-window at counter 7
    mode = 1'b1; en = 1'b1;
    n = 0;
    while (m_cnt != 7 && n < 60) begin
      lvds = 2'($urandom_range(0, 3));
      tick("seek7");
      n++;
    end
    chk("seek7_reached", 64'(m_cnt), 64'd7);
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_all("async_rst_hold");
    arst_n = 1'b1;
    ticks_to_valid("post_rst", n);
    chk("post_rst_window", 64'(n), 64'd17);
    repeat (20) begin
      lvds = 2'($urandom_range(0, 3));
      tick("tail");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lvds_sd_frontend.md
LVDS_SD_FRONTEND -- requirements
Module: lvds_sd_frontend

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: signed output sample width, minimum 4.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent LVDS sigma-delta channels, minimum 1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-004 SHALL have parameter DECIM, default 16: boxcar decimation ratio, minimum 2.
REQ-005 SHALL have parameter STUCK_LIMIT, default 1024: consecutive identical samples that raise the stuck flag, minimum 2.
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  enables sample production; high means run.
REQ-009 SHALL have port mode  input  1  output mode: 0 = raw ±1 per clock, 1 = boxcar decimate.
REQ-010 SHALL have port invert  input  NUM_CH  per-channel bit-polarity inversion.
REQ-011 SHALL have port lvds_in  input  NUM_CH  comparator bits from the LVDS receivers.
REQ-012 SHALL have port integrator_out  output  NUM_CH  registered feedback to the external RC integrators.
REQ-013 SHALL have port data_out  output  NUM_CH*DATA_WIDTH  signed samples; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port data_valid  output  1  one strobe shared by all channels, qualifying data_out.
REQ-015 SHALL have port stuck  output  NUM_CH  per-channel stuck-input flag.

Function
REQ-016 SHALL register integrator_out[c] from lvds_in[c] every clock, independent of en and mode.
REQ-017 SHALL pass integrator_out[c] through a SYNC_STAGES-deep register chain; the last stage XOR invert[c] is sample bit b[c].
REQ-018 SHALL map b=1 to -1 and b=0 to +1.
REQ-019 In raw mode with en=1, SHALL register the ±1 value, sign-extended to DATA_WIDTH, into data_out every clock with data_valid=1.
REQ-020 In raw mode, latency from lvds_in to data_out SHALL be SYNC_STAGES+2 clocks.
REQ-021 In boxcar mode, SHALL keep a shared window counter 0..DECIM-1 and one accumulator per channel, each clog2(DECIM)+2 bits signed.
REQ-022 In boxcar mode, on each en=1 clock with counter below DECIM-1, SHALL add the sample to the accumulator and increment the counter.
REQ-023 In boxcar mode, on the en=1 clock with counter at DECIM-1, SHALL write accumulator+sample to data_out, pulse data_valid for one clock, and clear the accumulator and counter.
REQ-024 SHALL saturate dumped sums to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 With en=0, counter and accumulators SHALL hold, data_valid SHALL be 0, and data_out SHALL hold its last value.
REQ-026 SHALL register mode internally; on any clock where mode differs from the registered value, SHALL clear counter and accumulators and drive data_valid=0; the new mode takes effect on the following clock.
REQ-027 SHALL keep a per-channel run counter of consecutive equal b[c], saturating at STUCK_LIMIT, running regardless of en.
REQ-028 stuck[c] SHALL be 1 while the run counter equals STUCK_LIMIT.
REQ-029 A toggle of b[c] SHALL reset the run counter to 1 and clear stuck[c] on the same edge.
REQ-030 Channels SHALL be fully independent except for the shared window counter and data_valid.

Reset
REQ-031 While arst_n=0, SHALL immediately drive integrator_out, the sync chains, data_out, data_valid, stuck, the counters, the accumulators and the registered mode to 0.
REQ-032 After arst_n rises, the first boxcar window SHALL start at counter 0.
REQ-033 Assertion of arst_n mid-window SHALL discard the partial sums.

Verification (NUM_CH=2, SYNC_STAGES=2, DECIM=16, STUCK_LIMIT=8 unless stated)
REQ-034 Scenario: arst_n low mid-window at counter 7 -> all outputs 0 without waiting for a clock edge; after release, first data_valid 16 en-cycles after the pipeline fills.
REQ-035 Scenario: raw mode, lvds_in={0,1}, invert=0 -> ch0 data_out=0xFFF (-1) and ch1=0x001, 4 clocks after stimulus, data_valid=1 continuously; invert[0]=1 -> ch0=0x001.
REQ-036 Scenario: boxcar mode, ch0 alternating 1/0, ch1 constant 0 -> every 16 clocks ch0=0 and ch1=+16, data_valid high exactly one clock.
REQ-037 Scenario: DATA_WIDTH=4, boxcar, constant 0 -> data_out=+7; constant 1 -> -8 (saturated).
REQ-038 Scenario: en low for 5 clocks at counter 9, then mode toggled mid-window -> valid delayed exactly 5 clocks with unchanged sum; after the mode toggle, no valid on the change clock and a fresh 16-clock window.
REQ-039 Scenario: ch0 held constant -> stuck[0]=1 once 8 equal synced samples are counted; a single toggle -> stuck[0]=0 on that edge; stuck[1] unaffected throughout.
